// File: rtl/pf_recv_queue.sv
// pf_recv_queue: prefetch request queue plus a 2-entry completion response buffer.
// Request FIFO is DEPTH entries; a RUN/FLUSH state machine drains it whenever
// prefetch is disabled. Optional build macro PF_RECV_DEDUP_EN drops requests whose
// {tag,set} already sits in the queue and counts the drops in drop_cnt.
module pf_recv_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pf_req_valid,
  output logic        pf_req_ready,
  input  logic [20:0] pf_req_bits_tag,
  input  logic [8:0]  pf_req_bits_set,
  input  logic        pf_req_bits_needT,
  input  logic [6:0]  pf_req_bits_source,
  input  logic        pf_req_bits_isBOP,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [20:0] issue_bits_tag,
  output logic [8:0]  issue_bits_set,
  output logic        issue_bits_needT,
  output logic [6:0]  issue_bits_source,
  output logic        issue_bits_isBOP,
  input  logic        done_valid,
  output logic        done_ready,
  input  logic [20:0] done_bits_tag,
  input  logic [8:0]  done_bits_set,
  output logic        pf_resp_valid,
  input  logic        pf_resp_ready,
  output logic [20:0] pf_resp_bits_tag,
  output logic [8:0]  pf_resp_bits_set,
  input  logic        pf_l2_pf_en,
  output logic [7:0]  drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [20:0] tag;
    logic [8:0]  set;
    logic        needT;
    logic [6:0]  source;
    logic        isBOP;
  } req_t;

  typedef struct packed {
    logic [20:0] tag;
    logic [8:0]  set;
  } resp_t;

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e      state_q, state_d;
  req_t        mem_q [DEPTH];
  logic [AW:0] head_q, head_d, tail_q, tail_d;
  logic        q_empty, q_full, enq_hs, deq_hs, enq_push, dup_hit;
  req_t        in_req, head_req;

  assign in_req = '{tag: pf_req_bits_tag, set: pf_req_bits_set, needT: pf_req_bits_needT,
                    source: pf_req_bits_source, isBOP: pf_req_bits_isBOP};

  // Extra wrap bit on the pointers tells full from empty when the indices match.
  assign q_empty  = (head_q == tail_q);
  assign q_full   = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
  assign pf_req_ready = pf_l2_pf_en && !q_full && (state_q == S_RUN);
  assign issue_valid  = !q_empty && (state_q == S_RUN);
  assign enq_hs   = pf_req_valid && pf_req_ready;
  assign deq_hs   = issue_valid && issue_ready;
  assign enq_push = enq_hs && !dup_hit;

  assign head_req          = mem_q[head_q[AW-1:0]];
  assign issue_bits_tag    = head_req.tag;
  assign issue_bits_set    = head_req.set;
  assign issue_bits_needT  = head_req.needT;
  assign issue_bits_source = head_req.source;
  assign issue_bits_isBOP  = head_req.isBOP;

  // Queue state and pointer next-state; FLUSH empties the queue in its single cycle.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      S_RUN: begin
        if (!pf_l2_pf_en) state_d = S_FLUSH;
        if (enq_push)     tail_d  = tail_q + 1'b1;
        if (deq_hs)       head_d  = head_q + 1'b1;
      end
      S_FLUSH: begin
        head_d = '0;
        tail_d = '0;
        if (pf_l2_pf_en) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Queue control registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload storage; contents are only meaningful inside the head..tail window.
  always_ff @(posedge clock) begin
    if (enq_push) mem_q[tail_q[AW-1:0]] <= in_req;
  end

`ifdef PF_RECV_DEDUP_EN
  logic [AW:0] q_cnt;
  logic [AW-1:0] idx;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign q_cnt = tail_q - head_q;

  // Match the incoming {tag,set} against every occupied entry (walk from head).
  always_comb begin
    dup_hit = 1'b0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q[AW-1:0] + AW'(k);
      if (((AW+1)'(k) < q_cnt) && (mem_q[idx].tag == pf_req_bits_tag) &&
          (mem_q[idx].set == pf_req_bits_set))
        dup_hit = 1'b1;
    end
  end

  // Saturating drop counter next-state.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (enq_hs && dup_hit && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clock) begin
    if (reset) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign dup_hit  = 1'b0;
  assign drop_cnt = 8'd0;
`endif

  // ---------------- response buffer (2 entries, independent of enable/FLUSH)
  resp_t      rmem_q [2];
  logic [1:0] rhead_q, rhead_d, rtail_q, rtail_d;
  logic       r_empty, r_full, r_push, r_pop;
  resp_t      r_head;

  assign r_empty = (rhead_q == rtail_q);
  assign r_full  = (rhead_q[1] != rtail_q[1]) && (rhead_q[0] == rtail_q[0]);
  assign done_ready    = !r_full;
  assign pf_resp_valid = !r_empty;
  assign r_push  = done_valid && done_ready;
  assign r_pop   = pf_resp_valid && pf_resp_ready;
  assign r_head  = rmem_q[rhead_q[0]];
  assign pf_resp_bits_tag = r_head.tag;
  assign pf_resp_bits_set = r_head.set;

  // Response pointer next-state.
  always_comb begin
    rhead_d = rhead_q;
    rtail_d = rtail_q;
    if (r_push) rtail_d = rtail_q + 2'd1;
    if (r_pop)  rhead_d = rhead_q + 2'd1;
  end

  // Response pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rhead_q <= '0;
      rtail_q <= '0;
    end else begin
      rhead_q <= rhead_d;
      rtail_q <= rtail_d;
    end
  end

  // Response payload storage.
  always_ff @(posedge clock) begin
    if (r_push) rmem_q[rtail_q[0]] <= '{tag: done_bits_tag, set: done_bits_set};
  end
endmodule

// File: tb/tb_pf_recv_queue.sv
// tb_pf_recv_queue: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a queue-based reference model.
module tb_pf_recv_queue;
  localparam int DEPTH = 4;
`ifdef PF_RECV_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  typedef struct packed {
    logic [20:0] tag;
    logic [8:0]  set;
    logic        needT;
    logic [6:0]  source;
    logic        isBOP;
  } req_t;
  typedef struct packed {
    logic [20:0] tag;
    logic [8:0]  set;
  } resp_t;

  logic clock = 1'b0, reset = 1'b1;
  logic pf_req_valid = 0, pf_req_ready;
  logic [20:0] pf_req_bits_tag = '0;
  logic [8:0]  pf_req_bits_set = '0;
  logic        pf_req_bits_needT = 0;
  logic [6:0]  pf_req_bits_source = '0;
  logic        pf_req_bits_isBOP = 0;
  logic issue_valid, issue_ready = 0;
  logic [20:0] issue_bits_tag;
  logic [8:0]  issue_bits_set;
  logic        issue_bits_needT;
  logic [6:0]  issue_bits_source;
  logic        issue_bits_isBOP;
  logic done_valid = 0, done_ready;
  logic [20:0] done_bits_tag = '0;
  logic [8:0]  done_bits_set = '0;
  logic pf_resp_valid, pf_resp_ready = 0;
  logic [20:0] pf_resp_bits_tag;
  logic [8:0]  pf_resp_bits_set;
  logic pf_l2_pf_en = 1;
  logic [7:0] drop_cnt;

  int n_vec = 0, n_bad = 0;
  bit chk_en = 0;

  pf_recv_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .pf_req_valid(pf_req_valid), .pf_req_ready(pf_req_ready),
    .pf_req_bits_tag(pf_req_bits_tag), .pf_req_bits_set(pf_req_bits_set),
    .pf_req_bits_needT(pf_req_bits_needT), .pf_req_bits_source(pf_req_bits_source),
    .pf_req_bits_isBOP(pf_req_bits_isBOP),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_bits_tag(issue_bits_tag), .issue_bits_set(issue_bits_set),
    .issue_bits_needT(issue_bits_needT), .issue_bits_source(issue_bits_source),
    .issue_bits_isBOP(issue_bits_isBOP),
    .done_valid(done_valid), .done_ready(done_ready),
    .done_bits_tag(done_bits_tag), .done_bits_set(done_bits_set),
    .pf_resp_valid(pf_resp_valid), .pf_resp_ready(pf_resp_ready),
    .pf_resp_bits_tag(pf_resp_bits_tag), .pf_resp_bits_set(pf_resp_bits_set),
    .pf_l2_pf_en(pf_l2_pf_en), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain queues of what is buffered
  req_t  mq[$];
  resp_t rq[$];
  bit    m_flush = 0;
  int    m_drop = 0;

  // Compare outputs to the model mid-cycle, then advance the model by the coming edge.
  always @(negedge clock) begin
    bit e_rdy, e_iv, e_dr, e_rv, acc, deq, dup, rpush, rpop;
    req_t r;
    e_rdy = pf_l2_pf_en && (mq.size() < DEPTH) && !m_flush;
    e_iv  = (mq.size() > 0) && !m_flush;
    e_dr  = rq.size() < 2;
    e_rv  = rq.size() > 0;
    if (chk_en) begin
      check("pf_req_ready", 64'(pf_req_ready), 64'(e_rdy));
      check("issue_valid", 64'(issue_valid), 64'(e_iv));
      if (e_iv)
        check("issue_bits", 64'({issue_bits_tag, issue_bits_set, issue_bits_needT,
                                 issue_bits_source, issue_bits_isBOP}), 64'(mq[0]));
      check("done_ready", 64'(done_ready), 64'(e_dr));
      check("pf_resp_valid", 64'(pf_resp_valid), 64'(e_rv));
      if (e_rv)
        check("pf_resp_bits", 64'({pf_resp_bits_tag, pf_resp_bits_set}), 64'(rq[0]));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
    if (reset) begin
      mq.delete(); rq.delete(); m_flush = 0; m_drop = 0;
    end else begin
      r = '{tag: pf_req_bits_tag, set: pf_req_bits_set, needT: pf_req_bits_needT,
            source: pf_req_bits_source, isBOP: pf_req_bits_isBOP};
      acc = pf_req_valid && e_rdy;
      deq = e_iv && issue_ready;
      dup = 0;
      foreach (mq[i]) if (DEDUP && mq[i].tag == r.tag && mq[i].set == r.set) dup = 1;
      if (deq) void'(mq.pop_front());
      if (acc && !dup) mq.push_back(r);
      if (acc && dup && m_drop < 255) m_drop++;
      if (m_flush) mq.delete();
      m_flush = !pf_l2_pf_en;
      rpop  = e_rv && pf_resp_ready;
      rpush = done_valid && e_dr;
      if (rpop) void'(rq.pop_front());
      if (rpush) rq.push_back('{tag: done_bits_tag, set: done_bits_set});
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic set_req(input bit v, input logic [20:0] t, input logic [8:0] s);
    pf_req_valid = v; pf_req_bits_tag = t; pf_req_bits_set = s;
    pf_req_bits_needT = t[0]; pf_req_bits_source = 7'(t + 21'd3); pf_req_bits_isBOP = s[0];
  endtask

  task automatic do_reset();
    reset = 1; step(); reset = 0;
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    #1;
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_resp_valid", 64'(pf_resp_valid), 64'd0);
    check("rst_done_ready", 64'(done_ready), 64'd1);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // latency-1 issue
    set_req(1, 21'h1, 9'h5); #1;
    check("req_ready_en", 64'(pf_req_ready), 64'd1);
    step(); set_req(0, 0, 0); #1;
    check("lat1_valid", 64'(issue_valid), 64'd1);
    check("lat1_tag", 64'(issue_bits_tag), 64'h1);
    check("lat1_set", 64'(issue_bits_set), 64'h5);

    // fill to DEPTH, then free one slot
    for (int i = 2; i <= 4; i++) begin set_req(1, 21'(i), 9'(i)); step(); end
    set_req(1, 21'h5, 9'h5); #1;
    check("full_ready", 64'(pf_req_ready), 64'd0);
    issue_ready = 1; step(); issue_ready = 0; set_req(0, 0, 0); #1;
    check("freed_ready", 64'(pf_req_ready), 64'd1);
    issue_ready = 1;
    for (int i = 2; i <= 4; i++) begin
      #1; check("order_tag", 64'(issue_bits_tag), 64'(i)); step();
    end
    issue_ready = 0; #1;
    check("drained", 64'(issue_valid), 64'd0);

    // flush with 3 queued
    for (int i = 7; i <= 9; i++) begin set_req(1, 21'(i), 9'd1); step(); end
    set_req(0, 0, 0); pf_l2_pf_en = 0; step(); pf_l2_pf_en = 1; #1;
    check("flush_iv0", 64'(issue_valid), 64'd0);
    step(); #1;
    check("flush_iv1", 64'(issue_valid), 64'd0);
    step(); #1;
    check("flush_empty", 64'(issue_valid), 64'd0);

    // duplicate requests
    set_req(1, 21'h2A, 9'h10); step(); step(); set_req(0, 0, 0); #1;
`ifdef PF_RECV_DEDUP_EN
    check("dedup_cnt1", 64'(drop_cnt), 64'd1);
    set_req(1, 21'h2A, 9'h10);
    for (int i = 0; i < 300; i++) step();
    set_req(0, 0, 0); #1;
    check("dedup_sat", 64'(drop_cnt), 64'd255);
    issue_ready = 1; step(); issue_ready = 0; #1;
    check("dedup_one_entry", 64'(issue_valid), 64'd0);
`else
    check("nodedup_cnt", 64'(drop_cnt), 64'd0);
    issue_ready = 1; step(); #1;
    check("nodedup_second", 64'(issue_valid), 64'd1);
    step(); issue_ready = 0; #1;
`endif

    // response buffer back-pressure
    pf_resp_ready = 0; done_valid = 1;
    done_bits_tag = 21'h100; done_bits_set = 9'h1; step();
    done_bits_tag = 21'h101; done_bits_set = 9'h2; step();
    done_bits_tag = 21'h102; done_bits_set = 9'h3; #1;
    check("resp_stall", 64'(done_ready), 64'd0);
    step(); pf_resp_ready = 1; #1;
    check("resp0", 64'(pf_resp_bits_tag), 64'h100);
    step(); #1;
    check("resp1", 64'(pf_resp_bits_tag), 64'h101);
    step(); done_valid = 0; #1;
    check("resp2", 64'(pf_resp_bits_tag), 64'h102);
    step(); pf_resp_ready = 0; #1;
    check("resp_empty", 64'(pf_resp_valid), 64'd0);

    // reset mid-operation
    set_req(1, 21'h33, 9'h3); step(); set_req(1, 21'h34, 9'h4); step(); set_req(0, 0, 0);
    done_valid = 1; done_bits_tag = 21'h55; step(); done_valid = 0;
    do_reset(); #1;
    check("mrst_issue", 64'(issue_valid), 64'd0);
    check("mrst_resp", 64'(pf_resp_valid), 64'd0);
    check("mrst_drop", 64'(drop_cnt), 64'd0);

    // random phase; small tag/set pool provokes duplicates
    for (int c = 0; c < 4000; c++) begin
      set_req(($urandom_range(0, 3) != 0), 21'($urandom_range(0, 3)), 9'($urandom_range(0, 1)));
      pf_req_bits_needT = 1'($urandom); pf_req_bits_source = 7'($urandom);
      pf_req_bits_isBOP = 1'($urandom);
      issue_ready   = ($urandom_range(0, 2) == 0);
      done_valid    = 1'($urandom);
      done_bits_tag = 21'($urandom); done_bits_set = 9'($urandom);
      pf_resp_ready = 1'($urandom);
      pf_l2_pf_en   = ($urandom_range(0, 15) != 0);
      reset         = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0; set_req(0, 0, 0); done_valid = 0;
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
